decoder_dispatch: RTL and testbench
===================================

// Module: decoder_dispatch
// PURPOSE
//  Registered successor to the combinational one-hot decoder. Turns an index into
//  one-hot select lines for OUT_LEN destinations (PEs / PUs) and holds each
//  transaction until every selected destination acks.
//  Adds a valid/ready input handshake, broadcast mode, per-destination ack
//  tracking, a completion pulse and out-of-range index rejection.
//  Sits between the control/bus sequencer and the destination write-enables.
// PARAMETERS
//  IN_LEN   3              width of select index
//  OUT_LEN  (1 << IN_LEN)  number of destinations, 1..2**IN_LEN; may be non-power-of-two
//  DATA_W   16             width of the payload carried with the select
// PORTS
//  clk        in   1        clock; all state on rising edge
//  rstn       in   1        reset, asynchronous assert, active-low
//  in_valid   in   1        request present
//  in_ready   out  1        block can accept; in_ready = (state == IDLE)
//  in_sel     in   IN_LEN   destination index
//  in_bcast   in   1        1 = select all OUT_LEN destinations; in_sel ignored
//  in_data    in   DATA_W   payload
//  out_sel    out  OUT_LEN  one-hot (or all-ones on broadcast) pending-select mask
//  out_data   out  DATA_W   registered payload, stable for the whole transaction
//  out_ack    in   OUT_LEN  per-destination ack, sampled each cycle
//  done       out  1        1-cycle pulse: all selected destinations acked
//  err_oob    out  1        1-cycle pulse: in_sel >= OUT_LEN on a non-broadcast accept
// BEHAVIOUR
//  Reset (rstn=0, async): state=IDLE, out_sel=0, out_data=0, done=0, err_oob=0.
//   Any in-flight transaction is discarded with no done. After release: in_ready=1.
//  Accept = in_valid & in_ready.
//  FSM:
//   IDLE  -> ISSUE on an accept with a valid target.
//            pending = in_bcast ? {OUT_LEN{1}} : (1 << in_sel); out_data <= in_data.
//   IDLE  -> IDLE on an accept with non-bcast in_sel >= OUT_LEN.
//            Request consumed; err_oob=1 next cycle; out_sel stays 0.
//   ISSUE: out_sel = pending (registered). Each cycle pending <= pending & ~out_ack.
//          Acks on bits not in pending are ignored.
//   ISSUE -> IDLE when (pending & ~out_ack) == 0.
//            Same edge: out_sel <= 0, done <= 1 for one cycle.
//  Latency: accept at edge N -> out_sel valid after N. Single-target, ack on first
//   ISSUE cycle -> done high after edge N+1, in_ready high again after N+1.
//   Minimum of 2 cycles per transaction; no accept while in ISSUE.
//  Simultaneous acks of several bits in one cycle are all retired together.
//  Partial acks: out_sel drops each acked bit the cycle after its ack.
//  No timeout; ISSUE holds indefinitely until all acks arrive.
//  out_data changes only on accept. done and err_oob are never high in the same cycle.
//  OUT_LEN=1: bcast and sel=0 behave identically.
// TESTING
//  1 Reset release -> in_ready=1, out_sel=0, done=0, err_oob=0.
//  2 Unicast: sel=5, data=16'hBEEF, ack[5] on first ISSUE cycle -> out_sel=8'h20,
//    out_data=BEEF; done pulses once; in_ready=1 two cycles after accept.
//  3 Broadcast, OUT_LEN=8, acks 0x0F then 0xF0 -> out_sel 0xFF -> 0xF0 -> 0x00;
//    single done pulse; stray ack bits ignored.
//  4 OUT_LEN=6, sel=7 non-bcast -> err_oob pulse, out_sel=0, in_ready stays 1.
//    Same index with bcast=1 -> out_sel=6'h3F.
//  5 Assert rstn=0 mid-ISSUE with pending=0x0C -> out_sel=0 immediately (async),
//    no done; next unicast completes normally.
//  6 in_valid held high during ISSUE -> no second accept until done;
//    back-to-back stream gives 1 done per request, with data order preserved.

Source files
------------

// File: rtl/decoder_dispatch.sv
// Registered index-to-one-hot dispatcher: accepts one request at a time, drives
// the select mask and payload, and retires when every selected destination acks.
module decoder_dispatch #(
  parameter int IN_LEN  = 3,
  parameter int OUT_LEN = (1 << IN_LEN),
  parameter int DATA_W  = 16
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [IN_LEN-1:0]   in_sel,
  input  logic                in_bcast,
  input  logic [DATA_W-1:0]   in_data,
  output logic [OUT_LEN-1:0]  out_sel,
  output logic [DATA_W-1:0]   out_data,
  input  logic [OUT_LEN-1:0]  out_ack,
  output logic                done,
  output logic                err_oob,
  output logic                dbg_state
);

  // Handshake: a request transfers on any rising edge where in_valid and
  // in_ready are both high; in_ready depends only on state, never on in_valid.

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_ISSUE = 1'b1
  } state_t;

  localparam logic [IN_LEN:0] OUT_LEN_W = OUT_LEN[IN_LEN:0];

  state_t              state_q, state_d;
  logic [OUT_LEN-1:0]  pend_q, pend_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic [OUT_LEN-1:0]  onehot;
  logic [OUT_LEN-1:0]  remain;
  logic                sel_oob;

  always_comb begin
    onehot = '0;
    for (int i = 0; i < OUT_LEN; i++) begin
      onehot[i] = (in_sel == IN_LEN'(i));
    end
  end

  // Extra bit so a full 2**IN_LEN destination count compares correctly.
  assign sel_oob = ({1'b0, in_sel} >= OUT_LEN_W);
  assign remain  = pend_q & ~out_ack;

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    data_d  = data_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if (!in_bcast && sel_oob) begin
            err_d = 1'b1;
          end else begin
            state_d = S_ISSUE;
            pend_d  = in_bcast ? {OUT_LEN{1'b1}} : onehot;
            data_d  = in_data;
          end
        end
      end
      S_ISSUE: begin
        // Acks outside the pending mask fall away in the AND.
        pend_d = remain;
        if (remain == '0) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        pend_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      pend_q  <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      data_q  <= data_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_sel   = pend_q;
  assign out_data  = data_q;
  assign done      = done_q;
  assign err_oob   = err_q;
  assign dbg_state = (state_q == S_ISSUE);

endmodule

// File: tb/tb_decoder_dispatch.sv
// Bench for decoder_dispatch: an 8-destination and a 6-destination instance share
// stimulus and are compared every cycle against a transaction-level model.
module tb_decoder_dispatch;

  logic        clk = 1'b0;
  logic        rstn;
  logic        in_valid = 1'b0;
  logic [2:0]  in_sel = '0;
  logic        in_bcast = 1'b0;
  logic [15:0] in_data = '0;
  logic [7:0]  ack = '0;

  logic        rdy8, rdy6, done8, done6, err8, err6, st8, st6;
  logic [7:0]  sel8;
  logic [5:0]  sel6;
  logic [15:0] dat8, dat6;

  always #5 clk = ~clk;

  decoder_dispatch #(.IN_LEN(3)) dut8 (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(rdy8),
    .in_sel(in_sel), .in_bcast(in_bcast), .in_data(in_data),
    .out_sel(sel8), .out_data(dat8), .out_ack(ack),
    .done(done8), .err_oob(err8), .dbg_state(st8)
  );

  decoder_dispatch #(.IN_LEN(3), .OUT_LEN(6)) dut6 (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(rdy6),
    .in_sel(in_sel), .in_bcast(in_bcast), .in_data(in_data),
    .out_sel(sel6), .out_data(dat6), .out_ack(ack[5:0]),
    .done(done6), .err_oob(err6), .dbg_state(st6)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int n_accept8 = 0;
  int n_done8 = 0;

  // Transaction-level model per instance: index 0 = 8 outputs, 1 = 6 outputs.
  int          m_len [2] = '{8, 6};
  bit          m_busy[2];
  int unsigned m_pend[2];
  logic [15:0] m_data[2];
  bit          m_done[2];
  bit          m_err [2];
  logic [15:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_busy[k] = 0; m_pend[k] = 0; m_data[k] = '0; m_done[k] = 0; m_err[k] = 0;
    end
    exp_q.delete();
  endtask

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      int unsigned full;
      int unsigned a;
      full = (32'd1 << m_len[k]) - 1;
      a = 32'(ack) & full;
      m_done[k] = 0;
      m_err[k]  = 0;
      if (!m_busy[k]) begin
        if (in_valid) begin
          if (!in_bcast && int'(in_sel) >= m_len[k]) begin
            m_err[k] = 1;
          end else begin
            m_busy[k] = 1;
            m_pend[k] = in_bcast ? full : (32'd1 << in_sel);
            m_data[k] = in_data;
            if (k == 0) begin
              exp_q.push_back(in_data);
              n_accept8++;
            end
          end
        end
      end else begin
        m_pend[k] = m_pend[k] & ~a;
        if (m_pend[k] == 0) begin
          m_busy[k] = 0;
          m_done[k] = 1;
        end
      end
    end
  endtask

  task automatic check_outputs();
    logic [15:0] front;
    check_eq("ready8", rdy8, !m_busy[0]);
    check_eq("sel8",   sel8, m_pend[0]);
    check_eq("data8",  dat8, m_data[0]);
    check_eq("done8",  done8, m_done[0]);
    check_eq("err8",   err8, m_err[0]);
    check_eq("state8", st8, m_busy[0]);
    check_eq("ready6", rdy6, !m_busy[1]);
    check_eq("sel6",   sel6, m_pend[1]);
    check_eq("data6",  dat6, m_data[1]);
    check_eq("done6",  done6, m_done[1]);
    check_eq("err6",   err6, m_err[1]);
    check_eq("state6", st6, m_busy[1]);
    check_eq("excl8",  done8 & err8, 1'b0);
    check_eq("excl6",  done6 & err6, 1'b0);
    if (done8) begin
      n_done8++;
      if (exp_q.size() != 0) begin
        front = exp_q.pop_front();
        check_eq("order8", dat8, front);
      end else begin
        check_eq("order8_extra_done", 1'b1, 1'b0);
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic drive(input logic v, input logic [2:0] s, input logic b,
                       input logic [15:0] d, input logic [7:0] a);
    in_valid = v; in_sel = s; in_bcast = b; in_data = d; ack = a;
  endtask

  initial begin
    rstn = 1'b1;
    model_reset();
    #1 rstn = 1'b0;
    @(negedge clk);
    check_eq("rst_sel8", sel8, 8'h00);
    check_eq("rst_done8", done8, 1'b0);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    check_eq("rel_ready8", rdy8, 1'b1);
    check_eq("rel_err8", err8, 1'b0);
    check_outputs();

    // Unicast sel=5, acked on first ISSUE cycle.
    drive(1, 3'd5, 0, 16'hBEEF, 8'h00);
    cycle();
    check_eq("uni_sel", sel8, 8'h20);
    check_eq("uni_data", dat8, 16'hBEEF);
    check_eq("uni_busy", rdy8, 1'b0);
    drive(0, 3'd0, 0, 16'h0000, 8'h20);
    cycle();
    check_eq("uni_done", done8, 1'b1);
    check_eq("uni_ready", rdy8, 1'b1);
    drive(0, 3'd0, 0, 16'h0000, 8'h00);
    cycle();
    check_eq("uni_done_once", done8, 1'b0);

    // Broadcast with split acks and a stray repeat.
    drive(1, 3'($urandom_range(0, 7)), 1, 16'h1234, 8'h00);
    cycle();
    check_eq("bc_all", sel8, 8'hFF);
    check_eq("bc_all6", sel6, 6'h3F);
    drive(0, 3'd0, 0, 16'h0000, 8'h0F);
    cycle();
    check_eq("bc_half", sel8, 8'hF0);
    cycle();
    check_eq("bc_stray", sel8, 8'hF0);
    check_eq("bc_no_done", done8, 1'b0);
    drive(0, 3'd0, 0, 16'h0000, 8'hF0);
    cycle();
    check_eq("bc_clear", sel8, 8'h00);
    check_eq("bc_done", done8, 1'b1);
    drive(0, 3'd0, 0, 16'h0000, 8'h00);
    cycle();
    check_eq("bc_done_once", done8, 1'b0);

    // Out-of-range index on the 6-destination instance, then broadcast on it.
    drive(1, 3'd7, 0, 16'h7777, 8'h00);
    cycle();
    check_eq("oob_err", err6, 1'b1);
    check_eq("oob_sel", sel6, 6'h00);
    check_eq("oob_ready", rdy6, 1'b1);
    drive(1, 3'd7, 1, 16'h6666, 8'h80);
    cycle();
    check_eq("oob_bc_sel", sel6, 6'h3F);
    check_eq("oob_bc_err", err6, 1'b0);
    drive(0, 3'd0, 0, 16'h0000, 8'hFF);
    cycle();
    drive(0, 3'd0, 0, 16'h0000, 8'h00);
    cycle();

    // Asynchronous reset while two destinations are still pending.
    drive(1, 3'd0, 1, 16'h5555, 8'h00);
    cycle();
    drive(0, 3'd0, 0, 16'h0000, 8'hF3);
    cycle();
    check_eq("mid_pend", sel8, 8'h0C);
    drive(0, 3'd0, 0, 16'h0000, 8'h00);
    rstn = 1'b0;
    #1;
    check_eq("async_sel8", sel8, 8'h00);
    check_eq("async_sel6", sel6, 6'h00);
    check_eq("async_ready", rdy8, 1'b1);
    model_reset();
    @(negedge clk);
    check_eq("async_no_done", done8, 1'b0);
    @(negedge clk);
    rstn = 1'b1;
    drive(1, 3'd2, 0, 16'hABCD, 8'h00);
    cycle();
    drive(0, 3'd0, 0, 16'h0000, 8'h04);
    cycle();
    check_eq("post_rst_done", done8, 1'b1);
    check_eq("post_rst_data", dat8, 16'hABCD);

    // Random stream: valid mostly held high, so requests wait through ISSUE.
    n_accept8 = 0;
    n_done8 = 0;
    for (int i = 0; i < 600; i++) begin
      drive(logic'($urandom_range(0, 9) < 8), 3'($urandom_range(0, 7)),
            logic'($urandom_range(0, 4) == 0), 16'($urandom),
            8'($urandom_range(0, 255) & ($urandom_range(0, 3) == 0 ? 8'h00 : 8'hFF)));
      cycle();
    end
    drive(0, 3'd0, 0, 16'h0000, 8'hFF);
    cycle();
    cycle();
    check_eq("done_count", n_done8, n_accept8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
